data_mem_access_unit: RTL and testbench

Memory-stage access unit between the pipeline's memory-stage outputs (ALU-computed address, store data, memory write enable, funct3) and a word-wide data bus with a req/ack handshake.
It performs byte/half/word alignment, write-strobe generation and load extraction with sign or zero extension.
It stalls the pipeline via the hazard unit until the bus acknowledges.
Its read_data output feeds the writeback pipeline register.

---
 rtl/data_mem_access_unit.sv | 134 +++++++++++++
 tb/tb_data_mem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// Memory-stage access unit: aligns loads/stores onto a word-wide req/ack data bus,
// generates byte strobes, extends load results, and stalls the pipeline until ack.
module data_mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   write_data,
    output logic [XLEN-1:0]   read_data,
    output logic              stall_mem,
    output logic              access_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int NB = XLEN / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_off;
    logic            legal;
    logic            aligned;
    logic            accept;
    logic [NB-1:0]   strb_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_value;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = !we;
            default:          legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3[1:0])
            2'd1:    aligned = !addr[0];
            2'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept = req_valid && legal && aligned;
    end

    assign stall_mem = !reset && ((state == IDLE && accept) || state == BUSY);

    always_comb begin
        strb_next  = '1;
        wdata_next = write_data;
        case (funct3[1:0])
            2'd0: begin
                strb_next  = NB'(1) << addr[1:0];
                wdata_next = {NB{write_data[7:0]}};
            end
            2'd1: begin
                strb_next  = NB'(3) << {addr[1], 1'b0};
                wdata_next = {(NB/2){write_data[15:0]}};
            end
            default: begin
                strb_next  = '1;
                wdata_next = write_data;
            end
        endcase
    end

    // Extraction uses the offset/size captured at request time, not the live inputs.
    always_comb begin
        shifted    = bus_rdata >> {ld_off, 3'b000};
        load_value = shifted;
        case (ld_funct3)
            3'd0:    load_value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'd4:    load_value = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'd1:    load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'd5:    load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            read_data    <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wstrb    <= '0;
            access_fault <= 1'b0;
            ld_funct3    <= '0;
            ld_off       <= '0;
        end else begin
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !(legal && aligned)) begin
                        access_fault <= 1'b1;
                    end else if (accept) begin
                        bus_req   <= 1'b1;
                        bus_we    <= we;
                        bus_addr  <= {addr[XLEN-1:2], 2'b00};
                        bus_wdata <= we ? wdata_next : '0;
                        bus_wstrb <= we ? strb_next : '0;
                        ld_funct3 <= funct3;
                        ld_off    <= addr[1:0];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) read_data <= load_value;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: a transaction-level model sets the
// expected per-cycle outputs and a single negedge process compares them.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall_mem;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    data_mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .we(we), .funct3(funct3),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .stall_mem(stall_mem), .access_fault(access_fault), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic        check_en = 1'b0;
    logic        e_stall, e_req, e_fault, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wstrb;
    logic        pin_en = 1'b0;
    logic [31:0] pin_wdata;
    logic [3:0]  pin_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall_mem", 32'(stall_mem), 32'(e_stall));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            chk("access_fault", 32'(access_fault), 32'(e_fault));
            chk("read_data", read_data, e_rd);
            if (e_req) begin
                chk("bus_we", 32'(bus_we), 32'(e_we));
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_wdata", bus_wdata, e_wdata);
                chk("bus_wstrb", 32'(bus_wstrb), 32'(e_wstrb));
            end
        end
    end

    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic m_legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
        if (w && f3 > 3'd2) return 1'b0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic w, input logic [2:0] f3, input logic [31:0] wd);
        if (!w) return 32'h0;
        if (f3 == 3'd0) return (wd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int unsigned m;
        if (!w) return 4'h0;
        m = ((32'd1 << size_of(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, b, h;
        v = rd >> (8 * (a % 4));
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd5: return h;
            default: return v;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0;
        tick();
    endtask

    // Starts in an IDLE cycle; ack arrives k cycles after the request (k >= 1).
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int k, input logic [31:0] rdat);
        logic ok;
        ok = m_legal(w, f3, a);
        req_valid = 1'b1; we = w; funct3 = f3; addr = a; write_data = wd; bus_ack = 1'b0;
        e_stall = ok; e_req = 1'b0; e_fault = 1'b0;
        tick();
        if (!ok) begin
            req_valid = 1'b0;
            e_fault = 1'b1; e_stall = 1'b0;
            tick();
            e_fault = 1'b0;
            return;
        end
        e_req = 1'b1; e_stall = 1'b1; e_we = w;
        e_addr = a & ~32'd3;
        e_wdata = m_wdata(w, f3, wd);
        e_wstrb = m_wstrb(w, f3, a);
        for (int c = 1; c <= k; c++) begin
            addr = $urandom; write_data = $urandom;
            funct3 = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1));
            bus_ack = (c == k);
            bus_rdata = (c == k) ? rdat : $urandom;
            if (pin_en && c == 1) begin
                chk("pin_wstrb", 32'(bus_wstrb), 32'(pin_wstrb));
                chk("pin_wdata", bus_wdata, pin_wdata);
            end
            tick();
        end
        bus_ack = 1'b0;
        e_req = 1'b0; e_stall = 1'b0;
        if (!w) e_rd = m_load(f3, a, rdat);
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0;
        write_data = '0; bus_ack = 1'b0; bus_rdata = '0;
        e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rd = '0;
        tick(); tick();
        check_en = 1'b1;
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        tick();
        reset = 1'b0;
        idle();

        access(1'b0, 3'd2, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        chk("lw_lit", read_data, 32'hDEADBEEF);
        idle();
        access(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lb_lit", read_data, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h103, 32'h0, 2, 32'h80112233);
        chk("lbu_lit", read_data, 32'h00000080);
        idle();

        pin_en = 1'b1; pin_wstrb = 4'b1100; pin_wdata = 32'hABCDABCD;
        access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5, 32'h0);
        pin_en = 1'b0;
        chk("sh_keeps_rd", read_data, 32'h00000080);
        idle();

        access(1'b0, 3'd2, 32'h101, 32'h0, 1, 32'h0);
        idle();
        access(1'b1, 3'd3, 32'h104, 32'h55, 1, 32'h0);
        idle();
        access(1'b0, 3'd1, 32'h105, 32'h0, 1, 32'h0);
        access(1'b1, 3'd4, 32'h104, 32'h55, 1, 32'h0);
        chk("fault_keeps_rd", read_data, 32'h00000080);
        idle();

        access(1'b0, 3'd1, 32'h302, 32'h0, 1, 32'h8001_7FFF);
        access(1'b0, 3'd5, 32'h302, 32'h0, 3, 32'h8001_7FFF);
        chk("lhu_lit", read_data, 32'h00008001);
        access(1'b0, 3'd1, 32'h300, 32'h0, 1, 32'h1234_9ABC);
        chk("lh_lit", read_data, 32'hFFFF9ABC);
        access(1'b1, 3'd0, 32'h401, 32'hCAFE_F00D, 2, 32'h0);
        access(1'b1, 3'd1, 32'h400, 32'hCAFE_F00D, 1, 32'h0);
        access(1'b0, 3'd0, 32'h402, 32'h0, 1, 32'h007F_0000);

        req_valid = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h300; bus_ack = 1'b0;
        e_stall = 1'b1; e_req = 1'b0; e_fault = 1'b0;
        tick();
        reset = 1'b1;
        e_stall = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_wdata = '0; e_wstrb = '0;
        tick();
        reset = 1'b0; req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        e_req = 1'b0; e_stall = 1'b0; e_rd = '0;
        tick();
        chk("rst_mid_rd", read_data, 32'h0);
        idle();
        access(1'b0, 3'd2, 32'h300, 32'h0, 1, 32'h1357_9BDF);

        access(1'b1, 3'd2, 32'h500, 32'hA5A5_5A5A, 1, 32'h0);
        access(1'b0, 3'd2, 32'h500, 32'h0, 1, 32'hA5A5_5A5A);
        chk("b2b_lit", read_data, 32'hA5A55A5A);
        idle();
        idle();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
